// File: rtl/frame_sequencer.sv
// Frame sequencer for the 64x64 image buffer: receive a frame over the UART,
// apply a point operation in place, then stream the frame back out.
// The single-port pixel RAM is owned here and addressed row-major {row,col}.
module frame_sequencer #(
    parameter int unsigned ROW_W  = 6,
    parameter int unsigned COL_W  = 6,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned THRESH = 128,
    parameter int unsigned BRIGHT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              op,
    input  logic                    rx_valid,
    input  logic [DATA_W-1:0]       rx_data,
    input  logic                    tx_ready,
    output logic                    tx_start,
    output logic [DATA_W-1:0]       tx_data,
    output logic [ROW_W+COL_W-1:0]  mem_addr,
    output logic                    mem_we,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    busy,
    output logic [1:0]              phase,
    output logic                    frame_done,
    output logic                    rx_overrun
);

    localparam int unsigned ADDR_W = ROW_W + COL_W;
    localparam int unsigned SUM_W  = DATA_W + 1;
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [DATA_W-1:0] PIX_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_PROC_RD,
        S_PROC_WR,
        S_TX_RD,
        S_TX_LD,
        S_TX_WAIT
    } state_t;

    state_t              state;
    // Pixel counter {row,col}; the upper ROW_W bits are the row, col runs fastest.
    logic [ADDR_W-1:0]   addr;
    logic [1:0]          op_r;
    logic                recv_last;
    logic [DATA_W-1:0]   wdata_r;
    logic [DATA_W-1:0]   proc_pix;
    logic [SUM_W-1:0]    bright_sum;

    // Point operation applied to the pixel read back during the PROC phase.
    always_comb begin
        bright_sum = {1'b0, mem_rdata} + SUM_W'(BRIGHT);
        case (op_r)
            2'd0:    proc_pix = mem_rdata;
            2'd1:    proc_pix = PIX_MAX - mem_rdata;
            2'd2:    proc_pix = (mem_rdata >= DATA_W'(THRESH)) ? PIX_MAX : '0;
            default: proc_pix = bright_sum[DATA_W] ? PIX_MAX : bright_sum[DATA_W-1:0];
        endcase
    end

    // Read data only arrives in the PROC_WR cycle itself, so the processed pixel
    // goes straight to the RAM; tx_start qualifies on the live tx_ready so a
    // byte is never launched into a busy transmitter.
    assign mem_wdata = (state == S_PROC_WR) ? proc_pix : wdata_r;
    assign tx_start  = (state == S_TX_WAIT) && tx_ready;
    assign busy      = (state != S_IDLE);

    // Phase decode: 0 idle, 1 receive, 2 process, 3 transmit.
    always_comb begin
        case (state)
            S_IDLE:               phase = 2'd0;
            S_RECV:               phase = 2'd1;
            S_PROC_RD, S_PROC_WR: phase = 2'd2;
            default:              phase = 2'd3;
        endcase
    end

    // Sequencer state, pixel counter and registered RAM/UART controls.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            addr       <= '0;
            op_r       <= '0;
            recv_last  <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            wdata_r    <= '0;
            tx_data    <= '0;
            frame_done <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            mem_we     <= 1'b0;
            frame_done <= 1'b0;
            if (rx_valid && (state != S_RECV)) rx_overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr       <= '0;
                        op_r       <= op;
                        recv_last  <= 1'b0;
                        rx_overrun <= 1'b0;
                        state      <= S_RECV;
                    end
                end
                S_RECV: begin
                    // Leave only after the final write cycle has been presented.
                    if (recv_last) begin
                        recv_last <= 1'b0;
                        mem_addr  <= addr;
                        state     <= S_PROC_RD;
                        if (rx_valid) rx_overrun <= 1'b1;
                    end else if (rx_valid) begin
                        mem_we   <= 1'b1;
                        mem_addr <= addr;
                        wdata_r  <= rx_data;
                        addr     <= addr + ADDR_W'(1);
                        if (addr == ADDR_LAST) recv_last <= 1'b1;
                    end
                end
                S_PROC_RD: begin
                    mem_we <= 1'b1;
                    state  <= S_PROC_WR;
                end
                S_PROC_WR: begin
                    addr     <= addr + ADDR_W'(1);
                    mem_addr <= addr + ADDR_W'(1);
                    state    <= (addr == ADDR_LAST) ? S_TX_RD : S_PROC_RD;
                end
                S_TX_RD: begin
                    state <= S_TX_LD;
                end
                S_TX_LD: begin
                    tx_data <= mem_rdata;
                    state   <= S_TX_WAIT;
                end
                S_TX_WAIT: begin
                    if (tx_ready) begin
                        addr     <= addr + ADDR_W'(1);
                        mem_addr <= addr + ADDR_W'(1);
                        if (addr == ADDR_LAST) begin
                            frame_done <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            state <= S_TX_RD;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with a behavioural synchronous RAM.
module tb_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        tx_ready = 1'b1;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'd0;
    logic        busy;
    logic [1:0]  phase;
    logic        frame_done;
    logic        rx_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    frame_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rx_valid(rx_valid), .rx_data(rx_data), .tx_ready(tx_ready),
        .tx_start(tx_start), .tx_data(tx_data), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .phase(phase), .frame_done(frame_done), .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    // Single-port RAM, read data one cycle after the address.
    logic [7:0] ram [4096];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Observation records, only ever appended to; tests work from baselines.
    int         cyc = 0;
    int         last_tx_cyc = -1;
    int         min_gap = 1000000;
    int         nr_viol = 0;
    int         fd_cnt = 0;
    int         fd_cyc = -1;
    int         proc_cyc = 0;
    int         proc_we = 0;
    logic [1:0] prev_ph = 2'd0;
    logic [7:0]  tx_q [$];
    logic [1:0]  ph_q [$];
    logic [7:0]  pw_q [$];
    logic [11:0] pa_q [$];

    always @(negedge clk) begin
        cyc++;
        if (tx_start === 1'b1) begin
            tx_q.push_back(tx_data);
            if (last_tx_cyc >= 0 && (cyc - last_tx_cyc) < min_gap) min_gap = cyc - last_tx_cyc;
            last_tx_cyc = cyc;
            if (tx_ready !== 1'b1) nr_viol++;
        end
        if (frame_done === 1'b1) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (phase !== prev_ph) begin
            ph_q.push_back(phase);
            prev_ph = phase;
        end
        if (phase === 2'd2) begin
            proc_cyc++;
            if (mem_we === 1'b1) begin
                proc_we++;
                pw_q.push_back(mem_wdata);
                pa_q.push_back(mem_addr);
            end
        end
    end

    function automatic logic [7:0] pix(input int kind, input int i);
        logic [7:0] v;
        v = i[7:0];
        if (kind == 2) begin
            case (i)
                0: v = 8'd127;
                1: v = 8'd128;
                2: v = 8'd0;
                3: v = 8'd255;
                default: ;
            endcase
        end else if (kind == 3) begin
            case (i)
                0: v = 8'd239;
                1: v = 8'd240;
                2: v = 8'd250;
                3: v = 8'd10;
                default: ;
            endcase
        end
        return v;
    endfunction

    function automatic logic [7:0] model(input int o, input logic [7:0] p);
        int v;
        case (o)
            0: v = int'(p);
            1: v = 255 - int'(p);
            2: v = (int'(p) > 127) ? 255 : 0;
            default: begin
                v = int'(p) + 16;
                if (v > 255) v = 255;
            end
        endcase
        return v[7:0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] o);
        start = 1'b1;
        op = o;
        tick();
        start = 1'b0;
        op = o ^ 2'b11;
    endtask

    task automatic send_frame(input int kind, input int gap, input int stray_at);
        for (int i = 0; i < 4096; i++) begin
            rx_valid = 1'b1;
            rx_data = pix(kind, i);
            tick();
            rx_valid = 1'b0;
            for (int g = 1; g < gap; g++) begin
                if (i == stray_at && g == 1) start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
    endtask

    task automatic wait_phase(input logic [1:0] p, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (phase === p) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_tx(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (tx_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_fd(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (fd_cnt >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        n_checks++;
        if ({tx_start, tx_data, mem_we, mem_wdata, mem_addr, busy, frame_done, rx_overrun} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, want 0",
                     {tx_start, tx_data, mem_we, mem_wdata, mem_addr, busy, frame_done, rx_overrun});
        end
        n_checks++;
        if (phase !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_phase: got %0d, want 0", phase);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_threshold_reset;
        bit ok;
        int b_pw, b_tx, mism;
        logic [7:0] exp4 [4];
        exp4 = '{8'd0, 8'd255, 8'd0, 8'd255};
        b_pw = pw_q.size();
        b_tx = tx_q.size();
        do_start(2'd2);
        send_frame(2, 1, -1);
        wait_phase(2'd3, 9000, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL thr_reach_tx: timeout, phase %0d, want 3", phase); end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (pw_q[b_pw+k] !== exp4[k] || pa_q[b_pw+k] !== 12'(k)) begin
                n_fail++;
                $display("FAIL thr_px%0d: got %0d @%0d, want %0d @%0d", k, pw_q[b_pw+k], pa_q[b_pw+k], exp4[k], k);
            end
        end
        mism = 0;
        for (int k = 0; k < 4096; k++)
            if (pw_q[b_pw+k] !== model(2, pix(2, k)) || pa_q[b_pw+k] !== 12'(k)) mism++;
        n_checks++;
        if (mism != 0 || pw_q.size() - b_pw != 4096) begin
            n_fail++;
            $display("FAIL thr_frame: %0d bad of %0d writes, want 0 bad of 4096", mism, pw_q.size() - b_pw);
        end
        wait_tx(b_tx + 2, 30, ok);
        n_checks++;
        if (!ok || tx_q[b_tx] !== 8'd0 || tx_q[b_tx+1] !== 8'd255) begin
            n_fail++;
            $display("FAIL thr_tx_first: got %0d,%0d, want 0,255", tx_q[b_tx], tx_q[b_tx+1]);
        end
        reset = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        n_checks++;
        if ({tx_start, tx_data, mem_we, mem_wdata, mem_addr, busy, phase, frame_done, rx_overrun} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_mid_tx: got %h, want 0",
                     {tx_start, tx_data, mem_we, mem_wdata, mem_addr, busy, phase, frame_done, rx_overrun});
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_brighten;
        bit ok;
        int b_pw, b_we;
        logic [7:0] exp4 [4];
        exp4 = '{8'd255, 8'd255, 8'd255, 8'd26};
        b_pw = pw_q.size();
        do_start(2'd3);
        send_frame(3, 1, -1);
        wait_phase(2'd2, 20, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL bri_reach_proc: timeout, phase %0d, want 2", phase); end
        repeat (10) tick();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (pw_q[b_pw+k] !== exp4[k]) begin
                n_fail++;
                $display("FAIL bri_px%0d: got %0d, want %0d", k, pw_q[b_pw+k], exp4[k]);
            end
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        b_we = proc_we;
        repeat (5) tick();
        n_checks++;
        if (phase !== 2'd0 || busy !== 1'b0 || proc_we != b_we) begin
            n_fail++;
            $display("FAIL bri_reset_abort: phase %0d busy %0d extra writes %0d, want 0 0 0",
                     phase, busy, proc_we - b_we);
        end
    endtask

    task automatic test_pass_through;
        bit ok;
        int b_tx, b_ph, b_fd, n0, chg, mism;
        logic [7:0] snap;
        logic [7:0] seq;
        b_tx = tx_q.size();
        b_ph = ph_q.size();
        b_fd = fd_cnt;
        do_start(2'd0);
        send_frame(0, 4, 100);
        wait_phase(2'd3, 9000, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL pass_reach_tx: timeout, phase %0d, want 3", phase); end
        wait_tx(b_tx + 10, 100, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL pass_first_tx: got %0d bytes, want 10", tx_q.size() - b_tx); end
        tx_ready = 1'b0;
        n0 = tx_q.size();
        repeat (3) tick();
        snap = tx_data;
        chg = 0;
        repeat (47) begin
            tick();
            if (tx_data !== snap) chg++;
        end
        n_checks++;
        if (tx_q.size() != n0) begin
            n_fail++;
            $display("FAIL bp_no_start: got %0d pulses while held, want 0", tx_q.size() - n0);
        end
        n_checks++;
        if (chg != 0) begin n_fail++; $display("FAIL bp_data_stable: got %0d changes, want 0", chg); end
        tx_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tx_start !== 1'b1) begin n_fail++; $display("FAIL bp_release: got tx_start %b, want 1", tx_start); end
        repeat (20) begin
            tick();
            tx_ready = ~tx_ready;
        end
        tx_ready = 1'b1;
        wait_fd(b_fd + 1, 20000, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL pass_frame_done: timeout, got %0d, want 1", fd_cnt - b_fd); end
        repeat (3) tick();
        mism = 0;
        for (int k = 0; k < 4096; k++)
            if (tx_q[b_tx+k] !== model(0, pix(0, k))) mism++;
        n_checks++;
        if (mism != 0 || tx_q.size() - b_tx != 4096) begin
            n_fail++;
            $display("FAIL pass_tx_data: %0d bad of %0d bytes, want 0 bad of 4096", mism, tx_q.size() - b_tx);
        end
        n_checks++;
        if (fd_cnt - b_fd != 1 || fd_cyc != last_tx_cyc + 1) begin
            n_fail++;
            $display("FAIL pass_done_pulse: got %0d pulses at +%0d, want 1 at +1", fd_cnt - b_fd, fd_cyc - last_tx_cyc);
        end
        seq = {ph_q[b_ph], ph_q[b_ph+1], ph_q[b_ph+2], ph_q[b_ph+3]};
        n_checks++;
        if (ph_q.size() - b_ph != 4 || seq !== 8'b01_10_11_00) begin
            n_fail++;
            $display("FAIL pass_phase_seq: got %0d changes %b, want 4 changes 01101100", ph_q.size() - b_ph, seq);
        end
        n_checks++;
        if (min_gap < 3 || nr_viol != 0) begin
            n_fail++;
            $display("FAIL tx_spacing: min gap %0d, not-ready pulses %0d, want >=3 and 0", min_gap, nr_viol);
        end
    endtask

    task automatic test_invert_overrun;
        bit ok;
        int b_tx, b_fd, pc0, pw0, mism;
        b_tx = tx_q.size();
        b_fd = fd_cnt;
        pc0 = proc_cyc;
        pw0 = proc_we;
        do_start(2'd1);
        send_frame(0, 1, -1);
        wait_phase(2'd2, 20, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL inv_reach_proc: timeout, phase %0d, want 2", phase); end
        repeat (100) tick();
        rx_valid = 1'b1;
        rx_data = 8'hAA;
        tick();
        rx_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rx_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b, want 1", rx_overrun); end
        wait_phase(2'd3, 9000, ok);
        n_checks++;
        if (!ok || proc_cyc - pc0 != 8192) begin
            n_fail++;
            $display("FAIL inv_proc_cycles: got %0d, want 8192", proc_cyc - pc0);
        end
        n_checks++;
        if (proc_we - pw0 != 4096) begin
            n_fail++;
            $display("FAIL inv_proc_writes: got %0d, want 4096", proc_we - pw0);
        end
        wait_fd(b_fd + 1, 14000, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL inv_frame_done: timeout, got %0d, want 1", fd_cnt - b_fd); end
        mism = 0;
        for (int k = 0; k < 4096; k++)
            if (tx_q[b_tx+k] !== model(1, pix(0, k))) mism++;
        n_checks++;
        if (mism != 0 || tx_q.size() - b_tx != 4096) begin
            n_fail++;
            $display("FAIL inv_tx_data: %0d bad of %0d bytes, want 0 bad of 4096", mism, tx_q.size() - b_tx);
        end
        tick();
        do_start(2'd0);
        @(negedge clk);
        n_checks++;
        if (rx_overrun !== 1'b0 || phase !== 2'd1) begin
            n_fail++;
            $display("FAIL overrun_clear: got overrun %b phase %0d, want 0 1", rx_overrun, phase);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_threshold_reset();
        test_brighten();
        test_pass_through();
        test_invert_overrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Top-level controller for the 64x64 8-bit image buffer. It owns the single-port pixel RAM and sequences it through three phases: receive a frame from the UART receiver, apply a point operation in place, then stream the frame out to the UART transmitter.
- Addressing is row-major, {row,col}, with col fastest; it replaces ad-hoc address generation in the receive path.

Parameters:
- ROW_W, 6, row counter width (64 rows)
- COL_W, 6, column counter width (64 cols)
- DATA_W, 8, pixel width
- THRESH, 128, threshold for op=2
- BRIGHT, 16, increment for op=3

Ports:
- clk  input  1  system clock, all logic on posedge
- reset  input  1  synchronous, active-low reset (asserted when 0)
- start  input  1  one-cycle pulse; begins a frame when in IDLE
- op  input  2  point operation: 0 pass, 1 invert, 2 threshold, 3 brighten
- rx_valid  input  1  one-cycle pulse, new byte on rx_data
- rx_data  input  DATA_W  received pixel
- tx_ready  input  1  transmitter idle and able to accept a byte
- tx_start  output  1  one-cycle pulse, tx_data valid
- tx_data  output  DATA_W  pixel to transmit (registered)
- mem_addr  output  ROW_W+COL_W  RAM address {row,col}
- mem_we  output  1  RAM write enable
- mem_wdata  output  DATA_W  RAM write data
- mem_rdata  input  DATA_W  RAM read data, valid 1 cycle after address
- busy  output  1  high in every state except IDLE
- phase  output  2  0 IDLE, 1 RECV, 2 PROC, 3 TX
- frame_done  output  1  one-cycle pulse after the last pixel is sent
- rx_overrun  output  1  sticky; rx_valid seen outside RECV; cleared on start

Behaviour:
- Reset (reset==0 at posedge):
  - state IDLE, row=col=0, op_r=0.
  - All outputs 0: tx_start, tx_data, mem_we, mem_wdata, mem_addr, busy, phase, frame_done, rx_overrun.
  - Reset overrides any phase mid-operation. No further RAM writes; a partial frame is abandoned.
- States: IDLE, RECV, PROC_RD, PROC_WR, TX_RD, TX_LD, TX_WAIT.
- IDLE:
  - mem_we=0.
  - On start: row=col=0, op_r<=op, rx_overrun<=0, next state RECV.
  - start in any other state is ignored.
- RECV:
  - Each rx_valid registers a write. Next cycle: mem_we=1, mem_addr={row,col}, mem_wdata=rx_data.
  - The counter advances in that same write cycle.
  - Back-to-back rx_valid on consecutive cycles must all be written.
  - After the write to (63,63): counters wrap to 0 and the state goes to PROC_RD.
- PROC, 2 cycles per pixel:
  - PROC_RD: mem_addr=A, mem_we=0.
  - PROC_WR: mem_addr=A, mem_we=1, mem_wdata=f(mem_rdata), then A++.
  - The whole phase is exactly 8192 cycles.
  - After the PROC_WR of (63,63): A wraps to 0, next state TX_RD.
  - op is sampled only at start (op_r); changing op mid-frame has no effect.
- f (8-bit, no wrap):
  - op 0: p.
  - op 1: 255-p.
  - op 2: p>=THRESH ? 255 : 0.
  - op 3: min(p+BRIGHT, 255), computed in 9 bits and saturated.
- TX:
  - TX_RD: mem_addr=A.
  - TX_LD: tx_data<=mem_rdata.
  - TX_WAIT: hold until tx_ready==1, then tx_start=1 for exactly one cycle and A++.
    - If A was (63,63): frame_done pulses the following cycle and the state goes to IDLE.
    - Otherwise: next state TX_RD.
  - tx_data stays stable from TX_LD until the next TX_LD.
  - Minimum spacing between tx_start pulses is 3 cycles; tx_start is never issued while tx_ready==0.
- rx_valid outside RECV:
  - Byte is dropped, rx_overrun<=1, no RAM write.
- mem_we is asserted only in the RECV write cycle and in PROC_WR.
- phase and busy are combinational decodes of the state.

Test Plan:
- Reset: hold reset=0 for 3 cycles mid-TX -> next cycle all outputs 0, phase=0. A following start with 4096 rx bytes runs a full frame normally.
- Pass-through frame: op=0, 4096 rx bytes with value i&255 at 1 pulse per 4 cycles -> TX bytes in order 0,1,…,255,0,… (4096 total). Exactly one frame_done after the last tx_start; phase sequence 1,2,3,0.
- Invert plus cycle count: op=1, same frame -> TX byte i = 255-(i&255). The PROC phase lasts exactly 8192 cycles and shows 4096 mem_we pulses.
- Threshold and brighten boundaries:
  - op=2 with pixels 127, 128, 0, 255 -> 0, 255, 0, 255.
  - op=3 with pixels 239, 240, 250 -> 255, 255, 255; pixel 10 -> 26.
- TX back-pressure: hold tx_ready=0 for 50 cycles in TX_WAIT -> tx_start stays 0 and tx_data is stable. After tx_ready rises, one tx_start pulse; toggling tx_ready never yields two pulses in under 3 cycles.
- Overrun and stray start: rx_valid during PROC -> rx_overrun=1, no extra mem_we, output frame unchanged. start pulsed during RECV -> ignored, counters continue.
